obj_table_commit: RTL and testbench

//  Avalon-MM front end that sits upstream of the sprite renderer. Software writes the background

---
 rtl/obj_table_commit.sv | 158 +++++++++++++++
 tb/tb_obj_table_commit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obj_table_commit.sv
// obj_table_commit
// Avalon-MM shadow/active object table for the sprite renderer. Software fills a
// shadow table (background colour plus MAX_OBJECTS object words); a commit request
// copies it into the active table at the start of vertical blank, one entry per clock.
// Optional build macro: FRAME_IRQ_EN enables the commit-done interrupt (addr 31 acks it).
module obj_table_commit #(
   parameter int          MAX_OBJECTS = 20,
   parameter logic [23:0] BG_RESET    = 24'h000020,
   parameter logic [9:0]  VBLANK_LINE = 10'd480
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      chipselect,
   input  logic                      write,
   input  logic                      read,
   input  logic [4:0]                address,
   input  logic [31:0]               writedata,
   output logic [31:0]               readdata,
   output logic                      waitrequest,
   input  logic [10:0]               hcount,
   input  logic [9:0]                vcount,
   output logic [23:0]               bg_rgb,
   output logic [32*MAX_OBJECTS-1:0] obj_words,
   output logic                      irq
);

   localparam logic [4:0] LAST_IDX  = 5'(MAX_OBJECTS);
   localparam logic [4:0] CTRL_ADDR = 5'd30;

   typedef enum logic [1:0] {IDLE, PENDING, COPY} state_t;

   state_t      state_q, state_d;
   logic [4:0]  idx_q;
   logic        repend_q;
   logic [15:0] frame_cnt_q;
   logic [23:0] shadow_bg_q;
   logic [23:0] active_bg_q;
   logic [31:0] shadow_obj_q [MAX_OBJECTS];
   logic [31:0] active_obj_q [MAX_OBJECTS];
   logic [31:0] status;
   logic [31:0] rd_mux;

   logic wr_en, rd_en, commit_req, shadow_sel, shadow_wr;
   logic in_copy, copy_last, vblank_tick;

   assign wr_en       = chipselect & write;
   assign rd_en       = chipselect & read;
   assign commit_req  = wr_en & (address == CTRL_ADDR) & writedata[0];
   assign shadow_sel  = wr_en & (address <= LAST_IDX);
   assign in_copy     = (state_q == COPY);
   // Shadow writes stall during the copy so the snapshot being committed stays coherent.
   assign waitrequest = in_copy & shadow_sel;
   assign shadow_wr   = shadow_sel & ~in_copy;
   assign copy_last   = in_copy & (idx_q == LAST_IDX);
   // hcount is zero for a single clock per line, so this is naturally a one-cycle pulse.
   assign vblank_tick = (vcount == VBLANK_LINE) && (hcount == 11'd0);

   // Commit FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Commit FSM next-state logic.
   always_comb begin
      // NOTE: the default is assigned first so no path through the case infers a latch.
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (commit_req)  state_d = PENDING;
         PENDING: if (vblank_tick) state_d = COPY;
         COPY:    if (copy_last)   state_d = (repend_q | commit_req) ? PENDING : IDLE;
         default:                  state_d = IDLE;
      endcase
   end

   // Copy index, re-request flag and completed-commit counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx_q       <= '0;
         repend_q    <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         idx_q <= (in_copy && !copy_last) ? idx_q + 5'd1 : 5'd0;
         if (copy_last) begin
            repend_q    <= 1'b0;
            frame_cnt_q <= frame_cnt_q + 16'd1;
         end else if (in_copy && commit_req) begin
            repend_q <= 1'b1;
         end
      end
   end

   // Shadow table: software-visible copy, frozen while the commit copy runs.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: the tables are flop arrays rather than RAM, so they take the async reset too.
      if (reset) begin
         shadow_bg_q <= BG_RESET;
         for (int i = 0; i < MAX_OBJECTS; i++) shadow_obj_q[i] <= '0;
      end else if (shadow_wr) begin
         if (address == 5'd0) shadow_bg_q <= writedata[23:0];
         for (int i = 0; i < MAX_OBJECTS; i++)
            if (address == 5'(i + 1)) shadow_obj_q[i] <= writedata;
      end
   end

   // Active table: idx 0 takes the background, idx k takes object k-1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         active_bg_q <= BG_RESET;
         for (int i = 0; i < MAX_OBJECTS; i++) active_obj_q[i] <= '0;
      end else if (in_copy) begin
         if (idx_q == 5'd0) active_bg_q <= shadow_bg_q;
         for (int i = 0; i < MAX_OBJECTS; i++)
            if (idx_q == 5'(i + 1)) active_obj_q[i] <= shadow_obj_q[i];
      end
   end

`ifdef FRAME_IRQ_EN
   localparam logic [4:0] ACK_ADDR = 5'd31;
   logic irq_q;
   logic ack_wr;
   assign ack_wr = wr_en & (address == ACK_ADDR);

   // Commit-done interrupt: set on copy completion, cleared by an ack write; set wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)          irq_q <= 1'b0;
      else if (copy_last) irq_q <= 1'b1;
      else if (ack_wr)    irq_q <= 1'b0;
   end
   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

   assign status = {frame_cnt_q, 13'd0, irq, in_copy, (state_q == PENDING) | repend_q};

   // Read address decode; unmapped addresses return zero.
   always_comb begin
      rd_mux = '0;
      if (address == 5'd0)       rd_mux = {8'h00, shadow_bg_q};
      if (address == CTRL_ADDR)  rd_mux = status;
      for (int i = 0; i < MAX_OBJECTS; i++)
         if (address == 5'(i + 1)) rd_mux = shadow_obj_q[i];
   end

   // Registered read data (latency 1); holds when no read is presented.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)      readdata <= '0;
      else if (rd_en) readdata <= rd_mux;
   end

   assign bg_rgb = active_bg_q;
   for (genvar g = 0; g < MAX_OBJECTS; g++) begin : g_obj_out
      assign obj_words[32*g +: 32] = active_obj_q[g];
   end

endmodule

// File: tb/tb_obj_table_commit.sv
// tb_obj_table_commit
// Directed stimulus against obj_table_commit with a transaction-level reference model
// (shadow table, commit snapshot, elapsed copy step) checked every cycle, plus
// hand-computed literal expectations. Honours FRAME_IRQ_EN when defined.
module tb_obj_table_commit;

   localparam int          MAX      = 20;
   localparam int          VW       = 32 * MAX;
   localparam logic [23:0] BG_RESET = 24'h000020;
`ifdef FRAME_IRQ_EN
   localparam logic IRQ_ON = 1'b1;
`else
   localparam logic IRQ_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          chipselect, write, read;
   logic [4:0]    address;
   logic [31:0]   writedata;
   logic [31:0]   readdata;
   logic          waitrequest;
   logic [10:0]   hcount;
   logic [9:0]    vcount;
   logic [23:0]   bg_rgb;
   logic [VW-1:0] obj_words;
   logic          irq;

   int n_pass  = 0;
   int n_total = 0;
   bit cmp_en  = 1'b0;

   obj_table_commit #(.MAX_OBJECTS(MAX), .BG_RESET(BG_RESET), .VBLANK_LINE(10'd480)) dut (
      .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .read(read),
      .address(address), .writedata(writedata), .readdata(readdata),
      .waitrequest(waitrequest), .hcount(hcount), .vcount(vcount),
      .bg_rgb(bg_rgb), .obj_words(obj_words), .irq(irq)
   );

   always #10 clk = ~clk;

   task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else             n_pass++;
   endtask

   // ---------------- reference model ----------------
   logic [23:0] m_sh_bg, m_act_bg, m_snap_bg;
   logic [31:0] m_sh_obj [MAX];
   logic [31:0] m_act_obj [MAX];
   logic [31:0] m_snap_obj [MAX];
   bit          m_wait_tick, m_copying, m_again, m_irq;
   int          m_step;
   logic [15:0] m_frames;
   logic [31:0] m_rd;

   function automatic logic [31:0] m_status();
      return {m_frames, 13'd0, m_irq, m_copying, m_wait_tick | m_again};
   endfunction

   function automatic logic [VW-1:0] m_pack();
      logic [VW-1:0] v;
      for (int i = 0; i < MAX; i++) v[32*i +: 32] = m_act_obj[i];
      return v;
   endfunction

   always @(posedge clk or posedge reset) begin : model
      bit wr, req, tick, sh_ok, start, done;
      if (reset) begin
         m_sh_bg = BG_RESET; m_act_bg = BG_RESET; m_snap_bg = BG_RESET;
         for (int i = 0; i < MAX; i++) begin
            m_sh_obj[i] = '0; m_act_obj[i] = '0; m_snap_obj[i] = '0;
         end
         m_wait_tick = 0; m_copying = 0; m_again = 0; m_irq = 0;
         m_step = 0; m_frames = '0; m_rd = '0;
      end else begin
         wr    = chipselect && write;
         req   = wr && address == 5'd30 && writedata[0];
         tick  = vcount == 10'd480 && hcount == 11'd0;
         sh_ok = wr && address <= 5'(MAX) && !m_copying;
         start = 0;
         done  = 0;
         if (chipselect && read) begin
            if (address == 5'd0)          m_rd = {8'h00, m_sh_bg};
            else if (address <= 5'(MAX))  m_rd = m_sh_obj[address - 5'd1];
            else if (address == 5'd30)    m_rd = m_status();
            else                          m_rd = '0;
         end
         if (m_copying) begin
            if (m_step == 0) m_act_bg = m_snap_bg;
            else             m_act_obj[m_step - 1] = m_snap_obj[m_step - 1];
            if (req) m_again = 1;
            if (m_step == MAX) begin
               m_copying = 0; m_frames++; done = 1;
               m_wait_tick = m_again; m_again = 0;
            end else begin
               m_step++;
            end
         end else if (m_wait_tick) begin
            if (tick) begin
               m_wait_tick = 0; m_copying = 1; m_step = 0; start = 1;
            end
         end else if (req) begin
            m_wait_tick = 1;
         end
`ifdef FRAME_IRQ_EN
         if (done)                          m_irq = 1;
         else if (wr && address == 5'd31)   m_irq = 0;
`endif
         if (sh_ok) begin
            if (address == 5'd0) m_sh_bg = writedata[23:0];
            else                 m_sh_obj[address - 5'd1] = writedata;
         end
         if (start) begin
            m_snap_bg = m_sh_bg;
            for (int i = 0; i < MAX; i++) m_snap_obj[i] = m_sh_obj[i];
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (cmp_en && !reset) begin
         check("cyc_bg_rgb", bg_rgb, m_act_bg);
         check("cyc_obj_words", obj_words, m_pack());
         check("cyc_waitrequest", waitrequest,
               m_copying && chipselect && write && address <= 5'(MAX));
         check("cyc_irq", irq, m_irq);
         check("cyc_readdata", readdata, m_rd);
      end
   end

   // ---------------- drivers ----------------
   task automatic next_cycle();
      @(posedge clk); #1;
   endtask

   task automatic bus_idle();
      chipselect = 0; write = 0; read = 0; address = '0; writedata = '0;
   endtask

   task automatic av_write(input logic [4:0] a, input logic [31:0] d, output int waits);
      chipselect = 1; write = 1; address = a; writedata = d; waits = 0;
      forever begin
         @(negedge clk);
         if (!waitrequest) break;
         waits++;
         if (waits > 100) begin
            check("write_wait_bound", waits, 0);
            break;
         end
      end
      next_cycle();
      bus_idle();
   endtask

   task automatic av_read(input logic [4:0] a, output logic [31:0] d);
      chipselect = 1; read = 1; address = a;
      next_cycle();
      bus_idle();
      d = readdata;
   endtask

   task automatic tick_pulse();
      vcount = 10'd480; hcount = 11'd0;
      next_cycle();
      vcount = 10'd0; hcount = 11'd100;
   endtask

   function automatic logic [31:0] st(input int frames, input logic pend);
      return {16'(frames), 13'd0, IRQ_ON, 1'b0, pend};
   endfunction

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed sequence ----------------
   initial begin : stim
      logic [31:0] d;
      int w;
      bus_idle();
      vcount = 10'd0; hcount = 11'd100;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      cmp_en = 1'b1;

      // Reset state
      check("rst_bg", bg_rgb, 24'h000020);
      check("rst_obj", obj_words, '0);
      check("rst_wait", waitrequest, 1'b0);
      check("rst_irq", irq, 1'b0);
      av_read(5'd30, d); check("rst_status", d, 32'h0);
      av_read(5'd0, d);  check("rst_shadow_bg", d, 32'h00000020);

      // Basic commit and copy latency
      av_write(5'd1, 32'h0C80F004, w);
      av_write(5'd30, 32'h1, w);
      av_read(5'd30, d); check("pend_status", d, 32'h1);
      tick_pulse();
      next_cycle(); check("obj0_tick_plus1", obj_words[31:0], 32'h0);
      next_cycle(); check("obj0_tick_plus2", obj_words[31:0], 32'h0C80F004);
      repeat (25) next_cycle();
      av_read(5'd30, d); check("frame1_status", d, st(1, 1'b0));
      check("bg_after_commit", bg_rgb, 24'h000020);

      // Shadow write without commit leaves the active table alone
      av_write(5'd1, 32'h12345678, w);
      tick_pulse();
      repeat (30) next_cycle();
      check("no_commit_obj0", obj_words[31:0], 32'h0C80F004);
      av_read(5'd1, d);  check("shadow_readback", d, 32'h12345678);
      av_read(5'd30, d); check("no_commit_status", d, st(1, 1'b0));

      // Shadow write stalled by COPY, re-request during COPY
      av_write(5'd30, 32'h1, w);
      tick_pulse();
      repeat (3) next_cycle();
      av_write(5'd30, 32'h1, w); check("ctrl_no_wait", w, 0);
      av_write(5'd5, 32'hAAAA5555, w); check("wr5_wait_cycles", w, 17);
      check("obj4_not_this_frame", obj_words[159:128], 32'h0);
      check("obj0_committed", obj_words[31:0], 32'h12345678);
      av_read(5'd30, d); check("repend_status", d, st(2, 1'b1));
      tick_pulse();
      repeat (25) next_cycle();
      check("obj4_next_frame", obj_words[159:128], 32'hAAAA5555);
      av_read(5'd30, d); check("frame3_status", d, st(3, 1'b0));

      // Request in the same cycle as the tick, then off-by-one tick positions
      chipselect = 1; write = 1; address = 5'd30; writedata = 32'h1;
      vcount = 10'd480; hcount = 11'd0;
      next_cycle();
      bus_idle(); vcount = 10'd0; hcount = 11'd100;
      repeat (25) next_cycle();
      av_read(5'd30, d); check("same_cycle_no_copy", d, st(3, 1'b1));
      vcount = 10'd480; hcount = 11'd1; next_cycle();
      vcount = 10'd479; hcount = 11'd0; next_cycle();
      vcount = 10'd0;   hcount = 11'd100;
      repeat (25) next_cycle();
      av_read(5'd30, d); check("near_tick_no_copy", d, st(3, 1'b1));
`ifdef FRAME_IRQ_EN
      av_write(5'd31, 32'h0, w); check("irq_ack", irq, 1'b0);
      tick_pulse();
      repeat (20) next_cycle();
      chipselect = 1; write = 1; address = 5'd31; writedata = 32'h0;
      next_cycle();
      bus_idle();
      check("irq_set_wins", irq, 1'b1);
      repeat (3) next_cycle();
`else
      tick_pulse();
      repeat (25) next_cycle();
      check("irq_tied_low", irq, 1'b0);
`endif
      av_read(5'd30, d); check("frame4_status", d, st(4, 1'b0));

      // Reset in the middle of a copy
      av_write(5'd0, 32'h00FF00FF, w);
      av_write(5'd2, 32'h0BADF00D, w);
      av_write(5'd30, 32'h1, w);
      tick_pulse();
      repeat (4) next_cycle();
      check("bg_mid_copy", bg_rgb, 24'hFF00FF);
      reset = 1'b1;
      #2;
      check("abort_bg", bg_rgb, 24'h000020);
      check("abort_obj", obj_words, '0);
      check("abort_irq", irq, 1'b0);
      check("abort_wait", waitrequest, 1'b0);
      next_cycle();
      reset = 1'b0;
      av_read(5'd30, d); check("abort_status", d, 32'h0);
      av_read(5'd2, d);  check("abort_shadow_obj1", d, 32'h0);
      repeat (3) next_cycle();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
